// File: rtl/mcu_pkg.sv
// Shared definitions for the program loader: loader states and frame constants.
package mcu_pkg;

  typedef enum logic [2:0] {
    IDLE, HDR, LO, HI, WR, CSUM, DONE, ERR
  } loader_state_e;

  localparam int BYTES_PER_WORD = 2;
  localparam int CSUM_W         = 8;

  // States in which the loader takes a byte off the stream.
  function automatic logic accepts(loader_state_e s);
    return s inside {HDR, LO, HI, CSUM};
  endfunction

endpackage

// File: rtl/program_loader.sv
// Byte-stream boot loader: header, LO/HI instruction byte pairs, checksum.
// Holds the core off fetch while writing program memory from address 0.
module program_loader
  import mcu_pkg::*;
#(
  parameter  int WIDTH  = 12,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [WIDTH-1:0]  load_instruction,
  output logic [ADDR_W-1:0] load_address,
  output logic              load_enable,
  output logic              cpu_hold,
  output logic              pm_enable,
  output logic              busy,
  output logic              done,
  output logic              load_err
);

  // Word count spans 1..256, so it needs one bit more than a byte.
  localparam int CNT_W = 9;

  loader_state_e     state, state_d;
  logic [CNT_W-1:0]  words_left;
  logic [CNT_W-1:0]  hdr_words;
  logic [CSUM_W-1:0] csum;
  logic              xfer;
  logic              oversize;

  assign xfer      = byte_valid && byte_ready;
  assign hdr_words = {1'b0, byte_in} + 9'd1;
  assign oversize  = int'(hdr_words) > DEPTH;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (start) state_d = HDR;
      HDR:       if (xfer) state_d = oversize ? ERR : LO;
      LO:        if (xfer) state_d = HI;
      HI:        if (xfer) state_d = WR;
      WR:        state_d = (words_left == 9'd1) ? CSUM : LO;
      CSUM:      if (xfer) state_d = (byte_in == csum) ? DONE : ERR;
      DONE, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      byte_ready       <= 1'b0;
      load_err         <= 1'b0;
      csum             <= '0;
      words_left       <= '0;
      load_address     <= '0;
      load_instruction <= '0;
    end else begin
      state      <= state_d;
      // Registered ready: mirrors whether the next state takes bytes.
      byte_ready <= accepts(state_d);
      if (state == IDLE && start) begin
        load_err     <= 1'b0;
        csum         <= '0;
        load_address <= '0;
      end
      if (state_d == ERR) load_err <= 1'b1;
      if (xfer && state inside {HDR, LO, HI}) csum <= csum + byte_in;
      if (xfer && state == HDR) words_left <= hdr_words;
      if (xfer && state == LO) load_instruction[7:0] <= byte_in;
      // Upper byte bits beyond WIDTH are dropped here but were summed above.
      if (xfer && state == HI) load_instruction[WIDTH-1:8] <= byte_in[WIDTH-9:0];
      if (state == WR) begin
        load_address <= load_address + 1'b1;
        words_left   <= words_left - 1'b1;
      end
    end
  end

  assign load_enable = (state == WR);
  assign busy        = (state != IDLE);
  assign cpu_hold    = busy;
  assign pm_enable   = ~cpu_hold;
  assign done        = (state == DONE) || (state == ERR);

endmodule
